// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control FSM: state codes,
// major opcodes, datapath mux selects and ALU-control operation classes.
package riscv_ctrl_pkg;

    // FSM state encoding (4 bits, visible on state_o)
    localparam logic [3:0] S_RESET    = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_EXEC_I   = 4'd4;
    localparam logic [3:0] S_ALU_WB   = 4'd5;
    localparam logic [3:0] S_MEM_ADDR = 4'd6;
    localparam logic [3:0] S_MEM_RD   = 4'd7;
    localparam logic [3:0] S_MEM_WB   = 4'd8;
    localparam logic [3:0] S_MEM_WR   = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JAL      = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd12;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Branch funct3 values handled by this core
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU  = 2'd0;
    localparam logic [1:0] PC_SRC_BR   = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP = 2'd2;

    // Register write-back select
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // ALU operand A select
    localparam logic [1:0] SRC_A_PC    = 2'd0;
    localparam logic [1:0] SRC_A_RS1   = 2'd1;
    localparam logic [1:0] SRC_A_OLDPC = 2'd2;

    // ALU operand B select
    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;

    // Operation class passed to ALU control
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    // States whose exit to FETCH marks an instruction as retired
    function automatic logic is_retire_state(input logic [3:0] s);
        return (s == S_ALU_WB) || (s == S_MEM_WB) || (s == S_MEM_WR) ||
               (s == S_BRANCH) || (s == S_JAL);
    endfunction

endpackage

// File: rtl/riscv_ctrl_perf_cnt.sv
// Cycle and retired-instruction counters for the multi-cycle control FSM.
// Both counters wrap modulo 2^CNT_W.
module riscv_ctrl_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             count_cycle_i,
    input  logic             retire_i,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instret_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    // Next count values
    always_comb begin
        cycle_d   = count_cycle_i ? cycle_q + CNT_ONE : cycle_q;
        instret_d = retire_i ? instret_q + CNT_ONE : instret_q;
    end

    // Counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_cnt_o   = cycle_q;
    assign instret_cnt_o = instret_q;

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I datapath. Sequences each instruction
// through fetch/decode/execute/memory/write-back, drives mux selects, write
// enables and the req/ready memory handshake, and traps on unknown opcodes,
// unsupported branch funct3 values or a memory wait timeout.
// Memory handshake: mem_req is held high until the cycle in which mem_ready is
// seen high; that cycle completes the access. mem_ready is ignored while
// mem_req is low.
// Optional performance counters are built when RISCV_CTRL_PERF_EN is defined.
module riscv_multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             illegal,
    output logic [3:0]       state_o
`ifdef RISCV_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    import riscv_ctrl_pkg::*;

    localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_ONE   = 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

    logic [3:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [WAIT_W-1:0] wait_inc;
    logic              wait_hit;
    logic              br_known;
    logic              br_taken;

    // Branch resolution and memory wait timeout detection
    always_comb begin
        br_known = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
        br_taken = ((funct3 == F3_BEQ) && zero) || ((funct3 == F3_BNE) && !zero);
        wait_inc = wait_q + WAIT_ONE;
        wait_hit = (MEM_WAIT_MAX != 0) && (wait_inc == WAIT_LIMIT);
    end

    // Next-state and wait-counter logic; the counter clears on any state exit
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                if (mem_ready) begin
                    case (state_q)
                        S_FETCH:  state_d = S_DECODE;
                        S_MEM_RD: state_d = S_MEM_WB;
                        default:  state_d = S_FETCH;
                    endcase
                end else if (wait_hit) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
                    OP_JAL:             state_d = S_JAL;
                    default:            state_d = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
            S_ALU_WB:           state_d = S_FETCH;
            S_MEM_ADDR:         state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_WB:           state_d = S_FETCH;
            S_BRANCH:           state_d = br_known ? S_FETCH : S_TRAP;
            S_JAL:              state_d = S_FETCH;
            S_TRAP:             state_d = S_TRAP;
            default:            state_d = S_TRAP;
        endcase
    end

    // State and wait-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RESET;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Datapath controls decoded from the state register (plus ready/taken gating)
    always_comb begin
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_SRC_ALU;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_ADD;
        illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
            end
            S_EXEC_R: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = ALU_FUNCT;
            end
            S_EXEC_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_FUNCT;
            end
            S_ALU_WB: reg_write = 1'b1;
            S_MEM_ADDR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEM_WB: begin
                reg_write = 1'b1;
                wb_sel    = WB_MEM;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = ALU_SUB;
                pc_src    = PC_SRC_BR;
                pc_write  = br_known && br_taken;
            end
            S_JAL: begin
                reg_write = 1'b1;
                wb_sel    = WB_PC4;
                pc_write  = 1'b1;
                pc_src    = PC_SRC_JUMP;
            end
            S_TRAP: illegal = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state_q;

`ifdef RISCV_CTRL_PERF_EN
    logic count_cycle;
    logic retire;

    // Counter enables: active cycles, and exits to FETCH that complete an instruction
    always_comb begin
        count_cycle = (state_q != S_RESET) && (state_q != S_TRAP);
        retire      = (state_d == S_FETCH) && is_retire_state(state_q);
    end

    riscv_ctrl_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk_i         (clk),
        .rst_i         (rst),
        .count_cycle_i (count_cycle),
        .retire_i      (retire),
        .cycle_cnt_o   (cycle_cnt),
        .instret_cnt_o (instret_cnt)
    );
`endif

endmodule
